// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light controller.
package f1_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LIGHTS = 3'd1,
        HOLD   = 3'd2,
        OUT    = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int unsigned LED_W      = 8;
    localparam int unsigned LFSR_DEF_W = 7;

    localparam logic [LED_W-1:0]      LEDS_ALL_ON = 8'hFF;
    localparam logic [LFSR_DEF_W-1:0] LFSR_SEED   = 7'd1;
    // x^7 + x^6 + 1: feedback from the two top bits
    localparam logic [LFSR_DEF_W-1:0] LFSR_TAPS   = 7'h60;

    function automatic logic [LED_W-1:0] light_next(input logic [LED_W-1:0] led);
        return {led[LED_W-2:0], 1'b1};
    endfunction

endpackage

// File: rtl/f1_start_ctrl_if.sv
// Control/result bundle between the start-light controller and its surroundings.
interface f1_start_ctrl_if #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned REACT_W = 16
);
    logic               trigger;
    logic               btn;
    logic [WIDTH-1:0]   N;
    logic [7:0]         led_num;
    logic [REACT_W-1:0] react_time;
    logic               react_valid;
    logic               jump_start;
    logic               busy;

    modport master (
        output trigger, btn, N,
        input  led_num, react_time, react_valid, jump_start, busy
    );

    modport slave (
        input  trigger, btn, N,
        output led_num, react_time, react_valid, jump_start, busy
    );
endinterface

// File: rtl/f1_prescaler.sv
// Tick generator: one-cycle tick every period+1 clocks while enabled.
module f1_prescaler #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] period,
    output logic             tick_c
);

    logic [WIDTH-1:0] count;

    assign tick_c = enable && (count == '0);

    // period is only sampled on load and on reload at zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= period;
        end else if (enable) begin
            if (count == '0) count <= period;
            else             count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/f1_start_ctrl.sv
// F1 start-light sequencer and reaction timer.
// Optional false-start detection is compiled in with F1_JUMP_START_EN.
module f1_start_ctrl
    import f1_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DELAY_W = 7,
    parameter int unsigned REACT_W = 16
) (
    input logic            clk,
    input logic            rst,
    f1_start_ctrl_if.slave bus
);

    localparam logic [DELAY_W-1:0] SEED = DELAY_W'(LFSR_SEED);
    localparam logic [DELAY_W-1:0] TAPS = DELAY_W'(LFSR_TAPS);

    state_t             state;
    logic [LED_W-1:0]   led_num;
    logic [REACT_W-1:0] react_time;
    logic               react_valid;
    logic               busy;
    logic [DELAY_W-1:0] lfsr;
    logic [DELAY_W-1:0] delay;
    logic [REACT_W-1:0] react_cnt;

    logic accept_c;
    logic running_c;
    logic tick_c;
    logic false_start_c;

    assign accept_c  = ((state == IDLE) || (state == DONE)) && bus.trigger;
    assign running_c = (state == LIGHTS) || (state == HOLD) || (state == OUT);

    f1_prescaler #(
        .WIDTH (WIDTH)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .load   (accept_c),
        .enable (running_c),
        .period (bus.N),
        .tick_c (tick_c)
    );

`ifdef F1_JUMP_START_EN
    logic jump_start;

    assign false_start_c = bus.btn && ((state == LIGHTS) || (state == HOLD));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               jump_start <= 1'b0;
        else if (accept_c)      jump_start <= 1'b0;
        else if (false_start_c) jump_start <= 1'b1;
    end

    assign bus.jump_start = jump_start;
`else
    assign false_start_c  = 1'b0;
    assign bus.jump_start = 1'b0;
`endif

    // Free-running Fibonacci LFSR; seeded non-zero so it never locks up
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= SEED;
        else      lfsr <= {lfsr[DELAY_W-2:0], ^(lfsr & TAPS)};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            led_num     <= '0;
            react_time  <= '0;
            react_valid <= 1'b0;
            busy        <= 1'b0;
            delay       <= '0;
            react_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (bus.trigger) begin
                        state       <= LIGHTS;
                        led_num     <= '0;
                        react_time  <= '0;
                        react_valid <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                LIGHTS: begin
                    if (false_start_c) begin
                        state       <= DONE;
                        led_num     <= '0;
                        react_time  <= '0;
                        react_valid <= 1'b1;
                        busy        <= 1'b0;
                    end else if (tick_c) begin
                        led_num <= light_next(led_num);
                        if (light_next(led_num) == LEDS_ALL_ON) begin
                            state <= HOLD;
                            delay <= lfsr;
                        end
                    end
                end
                HOLD: begin
                    if (false_start_c) begin
                        state       <= DONE;
                        led_num     <= '0;
                        react_time  <= '0;
                        react_valid <= 1'b1;
                        busy        <= 1'b0;
                    end else if (tick_c) begin
                        if (delay == DELAY_W'(1)) begin
                            state     <= OUT;
                            led_num   <= '0;
                            react_cnt <= '0;
                        end else begin
                            delay <= delay - DELAY_W'(1);
                        end
                    end
                end
                OUT: begin
                    // a press on a tick cycle captures the count before that tick
                    if (bus.btn) begin
                        state       <= DONE;
                        react_time  <= react_cnt;
                        react_valid <= 1'b1;
                        busy        <= 1'b0;
                    end else if (tick_c && (react_cnt != '1)) begin
                        react_cnt <= react_cnt + REACT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.led_num     = led_num;
    assign bus.react_time  = react_time;
    assign bus.react_valid = react_valid;
    assign bus.busy        = busy;

endmodule

// File: tb/tb_f1_start_ctrl.sv
// Directed scoreboard bench for f1_start_ctrl (16-bit and 4-bit reaction counters side by side).
module tb_f1_start_ctrl;
    import f1_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trigger = 1'b0;
    logic        btn = 1'b0;
    logic [15:0] n_period = 16'd4;

    always #5 clk = ~clk;

    f1_start_ctrl_if #(.WIDTH(16), .REACT_W(16)) bus16 ();
    f1_start_ctrl_if #(.WIDTH(16), .REACT_W(4))  bus4 ();

    assign bus16.trigger = trigger;
    assign bus16.btn     = btn;
    assign bus16.N       = n_period;
    assign bus4.trigger  = trigger;
    assign bus4.btn      = btn;
    assign bus4.N        = n_period;

    f1_start_ctrl #(.WIDTH(16), .DELAY_W(7), .REACT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    f1_start_ctrl #(.WIDTH(16), .DELAY_W(7), .REACT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    // Reference LFSR, x^7+x^6+1, seed 1
    logic [6:0] m_lfsr;
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= 7'd1;
        else      m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
    end

    typedef struct {
        string       tag;
        logic [7:0]  led;
        logic [15:0] rt;
        logic [3:0]  rt4;
        logic        rv;
        logic        js;
        logic        busy;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [7:0] led, input int rt,
                        input logic rv, input logic js, input logic busy);
        exp_t e;
        e.tag  = tag;
        e.led  = led;
        e.rt   = 16'(rt);
        e.rt4  = (rt > 15) ? 4'hF : 4'(rt);
        e.rv   = rv;
        e.js   = js;
        e.busy = busy;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".led"},  16'(bus16.led_num),     16'(e.led));
        chk({e.tag, ".rt"},   bus16.react_time,       e.rt);
        chk({e.tag, ".rt4"},  16'(bus4.react_time),   16'(e.rt4));
        chk({e.tag, ".rv"},   16'(bus16.react_valid), 16'(e.rv));
        chk({e.tag, ".js"},   16'(bus16.jump_start),  16'(e.js));
        chk({e.tag, ".busy"}, 16'(bus16.busy),        16'(e.busy));
    endtask

    // Trigger a run and follow the light-up; returns the predicted hold delay
    task automatic start_run(input logic btn_at_accept, output int d);
        logic [8:0] bar;
        int         np;
        np      = int'(n_period);
        d       = 0;
        trigger = 1'b1;
        btn     = btn_at_accept;
        step(1);
        trigger = 1'b0;
        btn     = 1'b0;
        push("accept", 8'h00, 0, 1'b0, 1'b0, 1'b1);
        check_out();
        for (int i = 1; i <= 8; i++) begin
            step(np);
            if (i == 8) d = int'(m_lfsr);
            step(1);
            bar = (9'd1 << i) - 9'd1;
            push("light", bar[7:0], 0, 1'b0, 1'b0, 1'b1);
            check_out();
        end
        chk("hold_entry_state", 16'(dut.state), 16'(HOLD));
    endtask

    task automatic hold_phase(input int d);
        int np1;
        np1 = int'(n_period) + 1;
        step(d * np1 - 1);
        push("hold_end", 8'hFF, 0, 1'b0, 1'b0, 1'b1);
        check_out();
        step(1);
        push("lights_out", 8'h00, 0, 1'b0, 1'b0, 1'b1);
        check_out();
    endtask

    // Press sampled k edges after lights-out
    task automatic react(input int k);
        int np1;
        np1 = int'(n_period) + 1;
        step(k - 1);
        btn = 1'b1;
        step(1);
        push("react", 8'h00, (k - 1) / np1, 1'b1, 1'b0, 1'b0);
        check_out();
        chk("done_state", 16'(dut.state), 16'(DONE));
        btn = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;

        // reset state
        step(3);
        push("reset", 8'h00, 0, 1'b0, 1'b0, 1'b0);
        check_out();
        chk("reset_state", 16'(dut.state), 16'(IDLE));
        @(negedge clk);
        rst = 1'b1;
        step(1);

        // N=4 light-up, hold, press 24 edges after lights-out -> 4 ticks
        n_period = 16'd4;
        start_run(1'b0, d);
        hold_phase(d);
        react(24);

        // press on the 3rd OUT tick cycle -> 2
        start_run(1'b0, d);
        hold_phase(d);
        react(15);

        // 20 ticks without press: 16-bit shows 20, 4-bit saturates at 15
        start_run(1'b0, d);
        hold_phase(d);
        react(101);

        // press already high at lights-out
        start_run(1'b0, d);
        hold_phase(d);
        react(1);

        // repeated runs over varying N (including N=0); first one also has btn with trigger in DONE
        for (int r = 0; r < 50; r++) begin
            n_period = 16'(r % 3);
            start_run(r == 0, d);
            hold_phase(d);
            react(int'($urandom_range(1, 12)));
        end

        // async reset in the middle of HOLD
        n_period = 16'd4;
        start_run(1'b0, d);
        step(2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        push("async_reset", 8'h00, 0, 1'b0, 1'b0, 1'b0);
        check_out();
        @(negedge clk);
        rst = 1'b1;
        step(1);
        start_run(1'b0, d);
        hold_phase(d);
        react(5);

        // btn during LIGHTS at 8'h07
        trigger = 1'b1;
        step(1);
        trigger = 1'b0;
        step(3 * 5);
        push("lights07", 8'h07, 0, 1'b0, 1'b0, 1'b1);
        check_out();
        btn = 1'b1;
        step(1);
`ifdef F1_JUMP_START_EN
        push("jump", 8'h00, 0, 1'b1, 1'b1, 1'b0);
        check_out();
        btn = 1'b0;
        step(1);
        start_run(1'b0, d);
`else
        push("nojump", 8'h07, 0, 1'b0, 1'b0, 1'b1);
        check_out();
        btn = 1'b0;
        step(4);
        push("continue", 8'h0F, 0, 1'b0, 1'b0, 1'b1);
        check_out();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/f1_start_ctrl.md
Name: f1_start_ctrl

Overview:
Top-level controller for the F1 start-light game. It sequences a tick prescaler and the eight-light bar through three phases:
- light-up, one light per tick;
- a pseudo-random hold with all lights on;
- lights-out.
It then measures driver reaction time in ticks until the button press. It replaces the free-running light demo with a triggered, self-timed sequence whose result is readable by the display logic.

Parameters:
WIDTH, 16, width of tick period input N
DELAY_W, 7, width of LFSR and hold-delay counter (delay range 1..2^DELAY_W-1 ticks)
REACT_W, 16, width of reaction-time counter

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
trigger  input  1  start request, synchronous level, sampled each clk
btn  input  1  driver button, synchronous, already debounced, level
N  input  WIDTH  tick period; tick every N+1 clk cycles
led_num  output  8  light bar, bit0 = first light
react_time  output  REACT_W  measured reaction in ticks
react_valid  output  1  react_time holds a result
jump_start  output  1  last run ended in a false start
busy  output  1  high in LIGHTS, HOLD, OUT

Behaviour:
- Reset (rst=0, async):
  - state IDLE;
  - led_num=0, react_time=0, react_valid=0, jump_start=0, busy=0;
  - prescaler count=0, delay=0;
  - LFSR=seed 1.
  - Outputs clear immediately, not at the next edge.
- Prescaler:
  - Runs only in LIGHTS/HOLD/OUT.
  - Loads N on trigger accept and decrements each cycle.
  - At 0: tick pulses for one cycle and the count reloads N.
  - First tick is N+1 cycles after the accept edge. N=0 gives a tick every cycle.
  - N is sampled only at load/reload.
- LFSR:
  - DELAY_W-bit Fibonacci, free-running every clk from reset.
  - Default taps x^7+x^6+1; never zero.
- State transitions (registered):
  - IDLE/DONE: trigger=1 -> LIGHTS; led_num=0, react_valid=0, jump_start=0, react_time=0, busy=1.
  - LIGHTS: on tick, led_num <= {led_num[6:0],1'b1}. The tick producing 8'hFF also moves to HOLD and latches delay <= LFSR value in that cycle.
  - HOLD: on tick, delay decrements. The tick with delay==1 -> OUT, led_num=0, reaction counter=0.
  - OUT: on tick, the counter increments and saturates at all-ones (no wrap). btn=1 -> DONE, react_time <= counter, react_valid=1, busy=0.
- Simultaneous events:
  - btn and tick in the same cycle in OUT: btn wins; the captured value excludes that tick's increment.
  - trigger and btn in the same cycle in DONE: trigger wins.
  - trigger in LIGHTS/HOLD/OUT: ignored.
- btn outside OUT: ignored, unless the Optional Feature is compiled in.
- btn already high at lights-out: DONE on the next edge with react_time=0.
- DONE holds led_num=0 and the results until the next trigger.

Optional Feature:
F1_JUMP_START_EN
- Defined: btn=1 in LIGHTS or HOLD -> DONE next edge with jump_start=1, react_valid=1, react_time=0, led_num=0, busy=0.
- Undefined: btn is ignored in LIGHTS/HOLD and jump_start is tied 0.

Decomposition:
- Package f1_pkg holds:
  - state enum (IDLE, LIGHTS, HOLD, OUT, DONE);
  - LFSR seed and tap constants;
  - light-bar all-on constant 8'hFF.
- One sub-module, f1_prescaler: load/enable/N in, tick out.
- LFSR, delay and reaction counters stay inline in f1_start_ctrl.

Test Plan:
1. N=4, trigger pulse at cycle 0 after reset:
   - led_num = 01, 03, 07, ... FF at cycles 5, 10, ... 40;
   - busy=1 from cycle 1;
   - HOLD entered at cycle 40.
2. HOLD duration: bench model of the LFSR predicts delay d at HOLD entry. Lights-out must occur exactly d*(N+1) cycles after HOLD entry, with 1<=d<=127; repeat over 50 triggers.
3. N=4, btn rises 23 cycles after lights-out:
   - react_time=4, react_valid=1, busy=0, led_num=0;
   - state DONE.
4. N=4, btn rises on the same cycle as the 3rd OUT tick -> react_time=2. Also check saturation: REACT_W=4, btn never pressed for 20 ticks, then btn -> react_time=15.
5. Async reset pulled low mid-HOLD:
   - led_num, busy, react_valid go to 0 without a clock edge;
   - after release, trigger restarts the sequence from led_num=0.
6. With F1_JUMP_START_EN, btn=1 during LIGHTS at led_num=07 -> jump_start=1, react_valid=1, react_time=0, led_num=0. Without the macro, the same stimulus must have no effect and the sequence continues.
